dmem_access_ctrl: RTL and testbench
===================================

Name: dmem_access_ctrl

Overview:
Sequences load/store instructions of the 8-bit single-cycle CPU onto a multi-cycle data memory. It takes the control unit's read/write requests, the ALU-computed address and the register-file write data. It drives the memory handshake and stalls the PC and register-file write (BUSYWAIT) until the access completes. It returns read data for register writeback, flags memory timeouts and keeps per-type access counters.

Parameters:
ADDR_W, 8, data memory address width (ALU result width)
DATA_W, 8, data word width
TIMEOUT, 255, max ACCESS cycles before abort; legal range 2..2^TO_W-1
TO_W, 8, wait-counter width
CNT_W, 16, width of each access counter

Ports:
CLK  input  1  system clock, posedge active
RESET  input  1  asynchronous, active-low reset
READ_REQ  input  1  control unit: current instruction is a load
WRITE_REQ  input  1  control unit: current instruction is a store
ADDRESS  input  ADDR_W  access address from ALU
WRITEDATA  input  DATA_W  store data from register file OUT1
BUSYWAIT  output  1  stall: freezes PC update and register write
READDATA  output  DATA_W  captured load data
READDATA_VALID  output  1  READDATA valid for writeback this cycle
ERR  output  1  sticky timeout / illegal-request flag
MEM_READ  output  1  memory read strobe
MEM_WRITE  output  1  memory write strobe
MEM_ADDRESS  output  ADDR_W  registered memory address
MEM_WRITEDATA  output  DATA_W  registered memory write data
MEM_READDATA  input  DATA_W  memory read data
MEM_BUSYWAIT  input  1  memory busy
RD_COUNT  output  CNT_W  completed loads, saturating
WR_COUNT  output  CNT_W  completed stores, saturating

Behaviour:
- Reset (RESET=0, async): state IDLE. All outputs 0, including MEM_READ/MEM_WRITE, which drop immediately even mid-access. Counters and ERR cleared.
- States: IDLE, ACCESS, DONE, ABORT; registered, one-hot or binary encoding.
- IDLE:
  - BUSYWAIT = READ_REQ|WRITE_REQ, combinational, so the request cycle itself stalls.
  - At posedge with a request: latch ADDRESS->MEM_ADDRESS, WRITEDATA->MEM_WRITEDATA, op type; clear wait counter; go to ACCESS.
  - READ_REQ&WRITE_REQ together: treated as a read; ERR set.
- ACCESS:
  - MEM_READ or MEM_WRITE held high per latched type. BUSYWAIT=1. Wait counter increments each posedge.
  - Completion: posedge with MEM_BUSYWAIT=0 and counter>=1. The first ACCESS edge is always skipped, to tolerate registered memory busywait.
  - On completion: for reads, capture MEM_READDATA into READDATA; go to DONE.
  - Timeout: counter reaches TIMEOUT without completion -> ABORT. Timeout has priority only if completion does not occur on that same edge.
- DONE:
  - Exactly one cycle. BUSYWAIT=0 and strobes low.
  - READDATA_VALID=1 for reads only.
  - RD_COUNT or WR_COUNT increments, saturating at all-ones.
  - READ_REQ/WRITE_REQ are ignored here: they belong to the retiring instruction.
  - Next state IDLE.
- ABORT:
  - One cycle. BUSYWAIT=0, strobes low, READDATA forced 0, READDATA_VALID=1 for reads. ERR set.
  - No counter increment. Next state IDLE.
- Latency: zero-wait memory gives request cycle + 2 ACCESS + DONE = 4 cycles, with BUSYWAIT high for 3. Each extra memory wait cycle adds 1.
- READDATA holds its value until the next completed or aborted read.
- ERR stays set until reset.
- MEM_ADDRESS and MEM_WRITEDATA are stable for the entire ACCESS window, even if inputs change.

Decomposition:
- Shared package/include cpu_defs:
  - state encodings (IDLE/ACCESS/DONE/ABORT)
  - load/store opcode constants used by the control unit to derive READ_REQ/WRITE_REQ
  - DATA_W/ADDR_W defaults
- One sub-module: sat_counter (CNT_W, enable, async active-low clear), instantiated twice for RD_COUNT and WR_COUNT.

Test Plan:
- Reset pulse mid-ACCESS with MEM_READ=1:
  - MEM_READ falls with RESET, no clock needed.
  - After release, state IDLE, counters 0, ERR 0.
- Load, ADDRESS=0x2A, memory busy 3 cycles then MEM_READDATA=0x5C:
  - MEM_READ high 5 cycles, MEM_ADDRESS=0x2A.
  - DONE cycle shows READDATA=0x5C, READDATA_VALID=1, RD_COUNT=1.
- Store, ADDRESS=0x10, WRITEDATA=0x99, zero-wait memory:
  - BUSYWAIT high exactly 3 cycles, MEM_WRITE high 2 cycles with MEM_WRITEDATA=0x99.
  - WR_COUNT=1, READDATA_VALID stays 0.
- TIMEOUT=4, MEM_BUSYWAIT stuck 1:
  - ABORT after 4 ACCESS cycles; READDATA=0x00, ERR=1 sticky.
  - RD_COUNT unchanged; next load still serviced.
- READ_REQ=WRITE_REQ=1 at ADDRESS=0x03:
  - Read performed, ERR=1.
  - Request held through DONE does not start a second access.
- Force RD_COUNT near saturation (CNT_W=2) and run 5 loads -> RD_COUNT holds at 3.

Source files
------------

// File: rtl/dmem_access_ctrl_pkg.sv
// Shared CPU definitions: memory-access FSM encodings, load/store opcodes
// and default datapath widths.
package cpu_defs;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2,
    ST_ABORT  = 2'd3
  } mem_state_t;

  // Opcodes the control unit decodes into READ_REQ / WRITE_REQ
  localparam logic [7:0] OP_LWD = 8'h08;
  localparam logic [7:0] OP_LWI = 8'h09;
  localparam logic [7:0] OP_SWD = 8'h0A;
  localparam logic [7:0] OP_SWI = 8'h0B;

endpackage

// File: rtl/dmem_access_ctrl_sat_counter.sv
// Saturating up-counter with enable and asynchronous active-low clear.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                cnt <= '0;
    else if (en && cnt != '1)  cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Sequences CPU loads/stores onto a multi-cycle data memory, stalling the
// core with BUSYWAIT until the access completes, times out, and is counted.
module dmem_access_ctrl
  import cpu_defs::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8,
  parameter int CNT_W   = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              READ_REQ,
  input  logic              WRITE_REQ,
  input  logic [ADDR_W-1:0] ADDRESS,
  input  logic [DATA_W-1:0] WRITEDATA,
  output logic              BUSYWAIT,
  output logic [DATA_W-1:0] READDATA,
  output logic              READDATA_VALID,
  output logic              ERR,
  output logic              MEM_READ,
  output logic              MEM_WRITE,
  output logic [ADDR_W-1:0] MEM_ADDRESS,
  output logic [DATA_W-1:0] MEM_WRITEDATA,
  input  logic [DATA_W-1:0] MEM_READDATA,
  input  logic              MEM_BUSYWAIT,
  output logic [CNT_W-1:0]  RD_COUNT,
  output logic [CNT_W-1:0]  WR_COUNT
);

  mem_state_t      state;
  logic            op_rd;
  logic [TO_W-1:0] wcnt;
  logic            done_evt;
  logic            to_evt;

  // The first ACCESS edge never completes so a registered memory busywait
  // has a cycle to assert before it is trusted.
  assign done_evt = (state == ST_ACCESS) && !MEM_BUSYWAIT && (wcnt != '0);
  assign to_evt   = (state == ST_ACCESS) && !done_evt && (wcnt == TO_W'(TIMEOUT - 1));

  always_comb begin
    BUSYWAIT = 1'b0;
    case (state)
      ST_IDLE:   BUSYWAIT = READ_REQ | WRITE_REQ;
      ST_ACCESS: BUSYWAIT = 1'b1;
      default:   BUSYWAIT = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state          <= ST_IDLE;
      op_rd          <= 1'b0;
      wcnt           <= '0;
      MEM_READ       <= 1'b0;
      MEM_WRITE      <= 1'b0;
      MEM_ADDRESS    <= '0;
      MEM_WRITEDATA  <= '0;
      READDATA       <= '0;
      READDATA_VALID <= 1'b0;
      ERR            <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          READDATA_VALID <= 1'b0;
          if (READ_REQ | WRITE_REQ) begin
            MEM_ADDRESS   <= ADDRESS;
            MEM_WRITEDATA <= WRITEDATA;
            op_rd         <= READ_REQ;
            MEM_READ      <= READ_REQ;
            MEM_WRITE     <= !READ_REQ;
            wcnt          <= '0;
            state         <= ST_ACCESS;
            // Conflicting request resolves as a load but is flagged
            if (READ_REQ && WRITE_REQ) ERR <= 1'b1;
          end
        end
        ST_ACCESS: begin
          wcnt <= wcnt + 1'b1;
          if (done_evt) begin
            MEM_READ       <= 1'b0;
            MEM_WRITE      <= 1'b0;
            READDATA_VALID <= op_rd;
            if (op_rd) READDATA <= MEM_READDATA;
            state          <= ST_DONE;
          end else if (to_evt) begin
            MEM_READ       <= 1'b0;
            MEM_WRITE      <= 1'b0;
            READDATA_VALID <= op_rd;
            if (op_rd) READDATA <= '0;
            ERR            <= 1'b1;
            state          <= ST_ABORT;
          end
        end
        // Requests seen here belong to the retiring instruction: ignore them
        default: begin
          READDATA_VALID <= 1'b0;
          state          <= ST_IDLE;
        end
      endcase
    end
  end

  // Counters step on the completing edge so the DONE cycle shows the new count
  sat_counter #(.CNT_W(CNT_W)) u_rd_cnt (
    .clk   (CLK),
    .rst_n (RESET),
    .en    (done_evt && op_rd),
    .cnt   (RD_COUNT)
  );

  sat_counter #(.CNT_W(CNT_W)) u_wr_cnt (
    .clk   (CLK),
    .rst_n (RESET),
    .en    (done_evt && !op_rd),
    .cnt   (WR_COUNT)
  );

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench: dut_a (default timeout, 2-bit counters) and dut_b
// (TIMEOUT=4) share CPU-side inputs but have separate memory busywait.
module tb_dmem_access_ctrl;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       READ_REQ = 1'b0, WRITE_REQ = 1'b0;
  logic [7:0] ADDRESS = '0, WRITEDATA = '0, MEM_READDATA = '0;
  logic       mbw_a = 1'b0, mbw_b = 1'b0;

  logic       bw_a, rdv_a, err_a, mr_a, mw_a;
  logic [7:0] rdata_a, maddr_a, mwdata_a;
  logic [1:0] rcnt_a, wcnt_a;
  logic       bw_b, rdv_b, err_b, mr_b, mw_b;
  logic [7:0] rdata_b, maddr_b, mwdata_b;
  logic [15:0] rcnt_b, wcnt_b;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  dmem_access_ctrl #(.TIMEOUT(255), .CNT_W(2)) dut_a (
    .CLK(CLK), .RESET(RESET), .READ_REQ(READ_REQ), .WRITE_REQ(WRITE_REQ),
    .ADDRESS(ADDRESS), .WRITEDATA(WRITEDATA), .BUSYWAIT(bw_a),
    .READDATA(rdata_a), .READDATA_VALID(rdv_a), .ERR(err_a),
    .MEM_READ(mr_a), .MEM_WRITE(mw_a), .MEM_ADDRESS(maddr_a),
    .MEM_WRITEDATA(mwdata_a), .MEM_READDATA(MEM_READDATA),
    .MEM_BUSYWAIT(mbw_a), .RD_COUNT(rcnt_a), .WR_COUNT(wcnt_a)
  );

  dmem_access_ctrl #(.TIMEOUT(4)) dut_b (
    .CLK(CLK), .RESET(RESET), .READ_REQ(READ_REQ), .WRITE_REQ(WRITE_REQ),
    .ADDRESS(ADDRESS), .WRITEDATA(WRITEDATA), .BUSYWAIT(bw_b),
    .READDATA(rdata_b), .READDATA_VALID(rdv_b), .ERR(err_b),
    .MEM_READ(mr_b), .MEM_WRITE(mw_b), .MEM_ADDRESS(maddr_b),
    .MEM_WRITEDATA(mwdata_b), .MEM_READDATA(MEM_READDATA),
    .MEM_BUSYWAIT(mbw_b), .RD_COUNT(rcnt_b), .WR_COUNT(wcnt_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  initial begin
    int hi, bwc, mwc, n;

    // ---- reset state and async drop of MEM_READ mid-access ----
    repeat (2) step();
    RESET = 1'b1;
    #1;
    chk("rst_busywait", 32'(bw_a), 32'd0);
    chk("rst_mem_read", 32'(mr_a), 32'd0);
    chk("rst_rd_count", 32'(rcnt_a), 32'd0);
    chk("rst_err", 32'(err_a), 32'd0);
    READ_REQ = 1'b1; ADDRESS = 8'h2A; mbw_a = 1'b1;
    #1;
    chk("req_cycle_busywait", 32'(bw_a), 32'd1);
    step();
    READ_REQ = 1'b0;
    chk("mid_access_mem_read", 32'(mr_a), 32'd1);
    #1 RESET = 1'b0;
    #1;
    chk("async_rst_mem_read", 32'(mr_a), 32'd0);
    chk("async_rst_busywait", 32'(bw_a), 32'd0);
    #1 RESET = 1'b1;
    mbw_a = 1'b0;
    step();
    chk("post_rst_busywait", 32'(bw_a), 32'd0);
    chk("post_rst_mem_read", 32'(mr_a), 32'd0);
    chk("post_rst_rd_count", 32'(rcnt_a), 32'd0);
    chk("post_rst_err", 32'(err_a), 32'd0);

    // ---- load 0x2A, memory busy 3 extra cycles, data 0x5C ----
    READ_REQ = 1'b1; ADDRESS = 8'h2A; mbw_a = 1'b1;
    step();
    READ_REQ = 1'b0; ADDRESS = 8'hFF;
    hi = 0;
    for (int c = 0; c < 20 && mr_a; c++) begin
      hi++;
      if (hi == 5) begin mbw_a = 1'b0; MEM_READDATA = 8'h5C; end
      step();
    end
    chk("load_mem_read_cycles", 32'(hi), 32'd5);
    chk("load_mem_address", 32'(maddr_a), 32'h2A);
    chk("load_readdata", 32'(rdata_a), 32'h5C);
    chk("load_rdv", 32'(rdv_a), 32'd1);
    chk("load_rd_count", 32'(rcnt_a), 32'd1);
    chk("load_done_busywait", 32'(bw_a), 32'd0);
    MEM_READDATA = 8'h00;
    step();
    chk("load_rdv_drop", 32'(rdv_a), 32'd0);
    chk("load_readdata_hold", 32'(rdata_a), 32'h5C);

    // ---- store 0x99 to 0x10, zero-wait memory ----
    WRITE_REQ = 1'b1; ADDRESS = 8'h10; WRITEDATA = 8'h99;
    bwc = 0; mwc = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (bw_a) bwc++;
      if (mw_a) begin
        mwc++;
        chk("store_mem_writedata", 32'(mwdata_a), 32'h99);
      end
      if (!bw_a) break;
      step();
      if (c == 0) begin WRITE_REQ = 1'b0; WRITEDATA = 8'h00; end
    end
    chk("store_busywait_cycles", 32'(bwc), 32'd3);
    chk("store_mem_write_cycles", 32'(mwc), 32'd2);
    chk("store_mem_address", 32'(maddr_a), 32'h10);
    chk("store_wr_count", 32'(wcnt_a), 32'd1);
    chk("store_rdv", 32'(rdv_a), 32'd0);
    step();

    // ---- timeout on dut_b (TIMEOUT=4) ----
    RESET = 1'b0; step(); RESET = 1'b1;
    READ_REQ = 1'b1; ADDRESS = 8'h40; MEM_READDATA = 8'h77;
    step(); READ_REQ = 1'b0;
    step(); step();
    chk("to_pre_readdata", 32'(rdata_b), 32'h77);
    chk("to_pre_rd_count", 32'(rcnt_b), 32'd1);
    step();
    mbw_b = 1'b1; READ_REQ = 1'b1;
    step(); READ_REQ = 1'b0;
    n = 0;
    for (int c = 0; c < 20; c++) begin
      if (!bw_b) break;
      n++;
      step();
    end
    chk("to_access_cycles", 32'(n), 32'd4);
    chk("to_readdata_zero", 32'(rdata_b), 32'h00);
    chk("to_rdv", 32'(rdv_b), 32'd1);
    chk("to_err", 32'(err_b), 32'd1);
    chk("to_rd_count_unchanged", 32'(rcnt_b), 32'd1);
    chk("to_mem_read_low", 32'(mr_b), 32'd0);
    step();
    chk("to_err_sticky", 32'(err_b), 32'd1);
    chk("to_rdv_drop", 32'(rdv_b), 32'd0);
    mbw_b = 1'b0; MEM_READDATA = 8'h31; READ_REQ = 1'b1;
    step(); READ_REQ = 1'b0;
    step(); step();
    chk("to_next_readdata", 32'(rdata_b), 32'h31);
    chk("to_next_rd_count", 32'(rcnt_b), 32'd2);
    chk("to_next_err_sticky", 32'(err_b), 32'd1);
    step();

    // ---- simultaneous read and write request ----
    RESET = 1'b0; step(); RESET = 1'b1;
    READ_REQ = 1'b1; WRITE_REQ = 1'b1; ADDRESS = 8'h03; MEM_READDATA = 8'h6E;
    step();
    chk("dual_mem_read", 32'(mr_a), 32'd1);
    chk("dual_mem_write", 32'(mw_a), 32'd0);
    chk("dual_err", 32'(err_a), 32'd1);
    chk("dual_mem_address", 32'(maddr_a), 32'h03);
    step(); step();
    chk("dual_readdata", 32'(rdata_a), 32'h6E);
    chk("dual_rdv", 32'(rdv_a), 32'd1);
    chk("dual_rd_count", 32'(rcnt_a), 32'd1);
    step();
    READ_REQ = 1'b0; WRITE_REQ = 1'b0;
    #1;
    chk("dual_no_restart_read", 32'(mr_a), 32'd0);
    chk("dual_no_restart_busy", 32'(bw_a), 32'd0);
    step();
    chk("dual_idle_mem_read", 32'(mr_a), 32'd0);
    chk("dual_wr_count", 32'(wcnt_a), 32'd0);

    // ---- RD_COUNT saturation with CNT_W=2 ----
    RESET = 1'b0; step(); RESET = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      READ_REQ = 1'b1; ADDRESS = 8'(k);
      step(); READ_REQ = 1'b0;
      step(); step();
      chk($sformatf("sat_rd_count_%0d", k), 32'(rcnt_a), (k > 3) ? 32'd3 : 32'(k));
      step();
    end
    chk("sat_err_clear", 32'(err_a), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
